// File: rtl/iir_pkg.sv
// Shared definitions for the second-order IIR low-pass sections.
// Holds datapath widths, the Q10 scaling constant, default numerator (zero)
// and denominator (pole) coefficients, and the MAC sequencer state encoding.
package iir_pkg;

  localparam int IIR_DW      = 12;  // input sample width
  localparam int IIR_CW      = 12;  // coefficient width, Q10
  localparam int IIR_OW      = 26;  // full-precision result width
  localparam int IIR_Q_SHIFT = 10;  // 1.0 == 1 << IIR_Q_SHIFT

  // Numerator: B0+B1+B2 = 99 pairs with the pole section for unity DC gain.
  localparam int IIR_B0 = 25;
  localparam int IIR_B1 = 49;
  localparam int IIR_B2 = 25;

  // Pole-section feedback coefficients, used by the recursive counterpart.
  localparam int IIR_A1 = 1911;
  localparam int IIR_A2 = -986;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MAC0 = 2'd1;
  localparam state_t ST_MAC1 = 2'd2;
  localparam state_t ST_MAC2 = 2'd3;

endpackage

// File: rtl/zero_mult.sv
// Combinational signed multiplier for the zero section: coef (CW) x samp (DW)
// -> prod (CW+DW). Kept in its own module so a vendor macro can replace it.
// Ports:
//   coef - signed coefficient
//   samp - signed sample
//   prod - signed full-width product
module zero_mult #(
  parameter int CW = 12,
  parameter int DW = 12
) (
  input  logic signed [CW-1:0]    coef,
  input  logic signed [DW-1:0]    samp,
  output logic signed [CW+DW-1:0] prod
);

  assign prod = coef * samp;

endmodule

// File: rtl/iir_zero_mac.sv
// Feed-forward (numerator) section of the second-order IIR low-pass.
// Computes dout = B0*x[n] + B1*x[n-1] + B2*x[n-2] in full precision (Q10,
// unscaled) with one multiplier shared over three MAC cycles.
// Ports:
//   clk        - system clock
//   rst_n      - synchronous reset, active HIGH despite the name
//   din_valid  - din carries a sample
//   din        - signed input sample
//   din_ready  - high while idle; a sample is taken on din_valid & din_ready
//   dout_valid - one-cycle pulse when dout has been updated
//   dout       - signed result, held until the next update
module iir_zero_mac
  import iir_pkg::*;
#(
  parameter int DW = IIR_DW,
  parameter int CW = IIR_CW,
  parameter int OW = IIR_OW,
  parameter int B0 = IIR_B0,
  parameter int B1 = IIR_B1,
  parameter int B2 = IIR_B2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_valid,
  input  logic signed [DW-1:0] din,
  output logic                 din_ready,
  output logic                 dout_valid,
  output logic signed [OW-1:0] dout
);

  localparam int PW = CW + DW;

  localparam logic signed [CW-1:0] COEF0 = CW'(B0);
  localparam logic signed [CW-1:0] COEF1 = CW'(B1);
  localparam logic signed [CW-1:0] COEF2 = CW'(B2);

  state_t state_q, state_d;

  logic signed [DW-1:0] x0_q, x1_q, x2_q;
  logic signed [OW-1:0] acc_q;
  logic signed [OW-1:0] dout_q;
  logic                 dout_valid_q;

  logic signed [CW-1:0] coef;
  logic signed [DW-1:0] samp;
  logic signed [PW-1:0] prod;
  logic signed [OW-1:0] prod_ext;

  assign din_ready  = (state_q == ST_IDLE);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

  // Operand select for the shared multiplier.
  always_comb begin
    coef = COEF0;
    samp = x0_q;
    case (state_q)
      ST_MAC1: begin
        coef = COEF1;
        samp = x1_q;
      end
      ST_MAC2: begin
        coef = COEF2;
        samp = x2_q;
      end
      default: begin
        coef = COEF0;
        samp = x0_q;
      end
    endcase
  end

  zero_mult #(
    .CW(CW),
    .DW(DW)
  ) u_zero_mult (
    .coef(coef),
    .samp(samp),
    .prod(prod)
  );

  // Sign-extend the product; 3 * 2^22 worst case fits, so no saturation.
  assign prod_ext = {{(OW - PW){prod[PW-1]}}, prod};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (din_valid) state_d = ST_MAC0;
      ST_MAC0: state_d = ST_MAC1;
      ST_MAC1: state_d = ST_MAC2;
      ST_MAC2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      x0_q         <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dout_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (din_valid) begin
            x2_q <= x1_q;
            x1_q <= x0_q;
            x0_q <= din;
          end
        end
        ST_MAC0: acc_q <= prod_ext;  // overwrite: starts a fresh sum
        ST_MAC1: acc_q <= acc_q + prod_ext;
        ST_MAC2: begin
          dout_q       <= acc_q + prod_ext;
          dout_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_zero_mac.sv
module tb_iir_zero_mac;

  logic clk = 1'b0;
  logic rst_n;

  logic               din_valid;
  logic signed [11:0] din;
  logic               din_ready;
  logic               dout_valid;
  logic signed [25:0] dout;

  logic               n_ready, n_valid, p_ready, p_valid;
  logic signed [25:0] n_dout, p_dout;
  logic signed [11:0] ext_din;

  always #5 clk = ~clk;

  iir_zero_mac u_dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .dout_valid(dout_valid), .dout(dout)
  );

  iir_zero_mac #(.B0(-2048), .B1(-2048), .B2(-2048)) u_neg (
    .clk(clk), .rst_n(rst_n), .din_valid(1'b1), .din(ext_din),
    .din_ready(n_ready), .dout_valid(n_valid), .dout(n_dout)
  );

  iir_zero_mac #(.B0(2047), .B1(2047), .B2(2047)) u_pos (
    .clk(clk), .rst_n(rst_n), .din_valid(1'b1), .din(ext_din),
    .din_ready(p_ready), .dout_valid(p_valid), .dout(p_dout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: sample history, cycles until result, pending/held result.
  int h0, h1, h2;
  int m_cnt, m_res, m_dout;
  logic m_valid, last_acc;
  int got[$];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    h0 = 0; h1 = 0; h2 = 0;
    m_cnt = 0; m_res = 0; m_dout = 0; m_valid = 1'b0;
  endtask

  // One clock: present (v, d), advance the model, compare all outputs.
  task automatic tick(input logic v, input int d);
    logic acc_now;
    din_valid = v;
    din       = 12'(d);
    acc_now   = v && (m_cnt == 0);
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    if (acc_now) begin
      h2 = h1; h1 = h0; h0 = int'($signed(12'(d)));
      m_res = 25 * h0 + 49 * h1 + 25 * h2;
      m_cnt = 3;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1'b1;
        m_dout  = m_res;
      end
    end
    last_acc = acc_now;
    check("dout_valid", 32'(dout_valid), 32'(m_valid));
    check("dout", dout, m_dout);
    check("din_ready", 32'(din_ready), (m_cnt == 0) ? 1 : 0);
    if (dout_valid) got.push_back(int'(dout));
  endtask

  task automatic send(input int d);
    int n = 0;
    do begin
      tick(1'b1, d);
      n++;
    end while (!last_acc && n < 8);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    check("rst_dout_valid", 32'(dout_valid), 0);
    check("rst_dout", dout, 0);
    check("rst_din_ready", 32'(din_ready), 1);
  endtask

  initial begin
    logic signed [25:0] held;
    din_valid = 1'b0;
    din       = '0;
    ext_din   = -12'sd2048;
    last_acc  = 1'b0;
    model_reset();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Impulse.
    got.delete();
    send(1024); send(0); send(0); send(0);
    idle(4);
    check("imp_count", got.size(), 4);
    if (got.size() == 4) begin
      check("imp0", got[0], 25600);
      check("imp1", got[1], 50176);
      check("imp2", got[2], 25600);
      check("imp3", got[3], 0);
    end

    // DC step with din_valid held: one acceptance per 4 clocks.
    got.delete();
    for (int i = 0; i < 16; i++) tick(1'b1, 1000);
    check("dc_count", got.size(), 4);
    if (got.size() == 4) begin
      check("dc0", got[0], 25000);
      check("dc1", got[1], 74000);
      check("dc2", got[2], 99000);
      check("dc3", got[3], 99000);
    end

    // Backpressure: random data every cycle, random valid.
    for (int i = 0; i < 80; i++)
      tick($urandom_range(0, 3) != 0, int'($signed(12'($urandom))));
    idle(4);

    // Reset while in MAC1.
    send(1024);
    tick(1'b0, 0);
    do_reset();
    idle(4);
    got.delete();
    send(1024);
    idle(4);
    check("post_rst_count", got.size(), 1);
    if (got.size() == 1) check("post_rst_imp", got[0], 25600);

    // Hold for 20 idle cycles.
    held = dout;
    idle(20);
    check("hold_dout", dout, held);

    // Extremes, running continuously since the last reset.
    check("ext_neg", n_dout, 12582912);
    check("ext_pos", p_dout, -12576768);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iir_zero_mac.md
Name: iir_zero_mac

Overview:
Feed-forward (zero/numerator) section of the second-order IIR low-pass. It is the counterpart of the recursive pole section.
- Accepts 12-bit signed input samples over a valid/ready handshake.
- Keeps a 3-tap delay line and computes b0*x[n] + b1*x[n-1] + b2*x[n-2] with one time-multiplexed multiplier.
- Emits a 26-bit full-precision Q10 result for the downstream summing node, which also receives the pole-section output.

Parameters:
- DW, 12, input sample width (signed)
- CW, 12, coefficient width (signed, Q10: 1024 = 1.0)
- OW, 26, output width (signed)
- B0, 25, numerator coefficient for x[n]
- B1, 49, numerator coefficient for x[n-1]
- B2, 25, numerator coefficient for x[n-2]; B0+B1+B2 = 99 gives unity DC gain against the pole section

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, synchronous reset, active-high (despite the name), sampled on rising clk
- din_valid, input, 1, din carries a sample
- din, input, DW, signed input sample
- din_ready, output, 1, block can accept a sample this cycle
- dout_valid, output, 1, one-cycle pulse: dout updated
- dout, output, OW, signed filtered result, Q10 unscaled

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - state=IDLE, delay line x0..x2=0, acc=0, dout=0, dout_valid=0.
  - din_ready=1 in the cycle after reset.
- FSM states: IDLE, MAC0, MAC1, MAC2. din_ready = (state==IDLE), combinational.
- IDLE:
  - On din_valid & din_ready, shift the delay line: x2<=x1, x1<=x0, x0<=din. Go to MAC0.
  - Otherwise stay in IDLE.
- MAC0: acc <= B0*x0 (acc overwritten, not accumulated). Go to MAC1.
- MAC1: acc <= acc + B1*x1. Go to MAC2.
- MAC2: dout <= acc + B2*x2, dout_valid <= 1. Go to IDLE.
- dout_valid is high only in the cycle after the MAC2 edge. Otherwise it is 0.
- Latency: sample accepted at edge T, dout_valid=1 during cycle T+3 (same cycle din_ready returns to 1).
- Throughput: one sample per 4 clocks.
- din_valid while busy (din_ready=0): sample not consumed. Upstream must hold din/din_valid until accepted. No internal buffering.
- A sample can be accepted in the same cycle dout_valid is high.
- dout holds its last value until the next MAC2 edge.
- Arithmetic:
  - Signed two's complement throughout. Product is CW+DW=24 bits, sign-extended to OW before accumulation.
  - No rounding, truncation or saturation. The worst case 3*2^22 fits in 26 bits, so no overflow is possible.
- Reset mid-operation (any MAC state):
  - Computation is aborted and no dout_valid is produced.
  - Delay line, acc and dout are cleared; state returns to IDLE.
- Single multiplier:
  - Operand mux selects (B0,x0), (B1,x1), (B2,x2) by state.
  - Multiplier is combinational, registered only through acc/dout.

Decomposition:
- Shared package iir_pkg:
  - DW/CW/OW widths and the Q10 shift constant (10).
  - Default numerator coefficients 25/49/25 and pole coefficients 1911/-986.
  - FSM state encoding typedef.
- One natural sub-module: zero_mult, a combinational signed CW x DW -> CW+DW multiplier. It is swappable for a vendor multiplier macro.

Test Plan:
- Impulse:
  - Stimulus: reset, then din=1024 followed by 0, 0, 0.
  - Response: dout sequence 25600, 50176, 25600, 0. Each dout_valid lands exactly 3 cycles after acceptance.
- DC step:
  - Stimulus: din=1000 held, din_valid held high.
  - Response: dout 25000, 74000, 99000, 99000, ...
  - din_ready pattern 1,0,0,0 repeating, so exactly one acceptance per 4 clocks.
- Extremes:
  - B0=B1=B2=-2048 and din=-2048 constant: steady-state dout=12582912.
  - B*=2047: steady-state dout=-12576768. No wrap in either case.
- Backpressure:
  - Stimulus: din changes every cycle while din_valid=1.
  - Response: only values present when din_ready=1 enter the delay line. Bench model must match every dout.
- Reset mid-operation:
  - Stimulus: assert rst_n during MAC1.
  - Response: no dout_valid, dout=0, din_ready=1 after reset. A subsequent impulse 1024 gives 25600 (delay line confirmed cleared).
- Hold and back-to-back:
  - After a result with din_valid=0 for 20 cycles: dout stays stable, dout_valid=0.
  - A sample presented in the dout_valid cycle is accepted that cycle.
